// File: rtl/result_hold_display.sv
// Result hold and display stage. A result is captured on done_tick and kept locked for at
// least HOLD_CYCLES cycles. It is shown on a 4-digit multiplexed seven-segment display.
// The ready output tells the engine when a new result will be accepted.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits of a shown result.
module result_hold_display #(
  parameter int unsigned HOLD_CYCLES = 12_500_000,
  parameter int unsigned SCAN_W      = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done_tick,
  input  logic [15:0] result,
  output logic        ready,
  output logic        hold_tick,
  output logic        overrun,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {StIdle, StHold, StShow} state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [15:0]        value_q, value_d;
  logic [SCAN_W-1:0]  cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               hold_tick_q, hold_tick_d;
  logic               overrun_q, overrun_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;
  logic [1:0]         digit;
  logic [3:0]         nibble;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] hex7(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Capture / hold / show sequencing and the status flags.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    value_d     = value_q;
    overrun_d   = overrun_q;
    hold_tick_d = 1'b0;
    case (state_q)
      StIdle, StShow: begin
        if (done_tick) begin
          value_d = result;
          hold_d  = HoldW'(HOLD_CYCLES - 1);
          state_d = StHold;
        end
      end
      StHold: begin
        // A result arriving while locked is dropped, even on the expiry cycle.
        if (done_tick) overrun_d = 1'b1;
        if (hold_q == '0) begin
          state_d     = StShow;
          hold_tick_d = 1'b1;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d != StHold);
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;
`endif

  // Display drive is computed from next-state values so it lines up with the registered status.
  always_comb begin
    cnt_d  = cnt_q + SCAN_W'(1);
    digit  = cnt_d[SCAN_W-1 -: 2];
    nibble = value_d[{digit, 2'b00} +: 4];
    an_d   = ~(4'b0001 << digit);
    sseg_d = (state_d == StIdle) ? 8'hBF : hex7(nibble);
`ifdef LEADING_ZERO_BLANK_EN
    case (digit)
      2'd1:    lead_zero = (value_d[15:4] == 12'h000);
      2'd2:    lead_zero = (value_d[15:8] == 8'h00);
      2'd3:    lead_zero = (value_d[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
    if (state_d != StIdle && lead_zero) begin
      an_d   = 4'hF;
      sseg_d = 8'hFF;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      value_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      hold_tick_q <= 1'b0;
      overrun_q   <= 1'b0;
      an_q        <= 4'b1110;
      sseg_q      <= 8'hBF;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      value_q     <= value_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      hold_tick_q <= hold_tick_d;
      overrun_q   <= overrun_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

  assign ready     = ready_q;
  assign hold_tick = hold_tick_q;
  assign overrun   = overrun_q;
  assign an        = an_q;
  assign sseg      = sseg_q;

endmodule

// File: tb/tb_result_hold_display.sv
// Bench for result_hold_display (HOLD_CYCLES=8, SCAN_W=4): directed vector table, hand-written
// corner sequences and random traffic, all compared against a cycle-count reference model.
module tb_result_hold_display;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        done_tick = 1'b0;
  logic [15:0] result = 16'h0000;
  logic        ready, hold_tick, overrun;
  logic [3:0]  an;
  logic [7:0]  sseg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: captured value, edges since capture, edges since reset.
  logic        m_valid;
  logic [15:0] m_value;
  logic        m_overrun;
  int          m_since;
  int          m_scan;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct packed {
    logic        rst;
    logic        dt;
    logic [15:0] res;
    logic        rdy;
    logic        tk;
    logic        ovr;
    logic [3:0]  an;
    logic [7:0]  sseg;
  } vec_t;

  vec_t vecs [14];

  result_hold_display #(
    .HOLD_CYCLES(HOLD),
    .SCAN_W     (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .done_tick(done_tick),
    .result   (result),
    .ready    (ready),
    .hold_tick(hold_tick),
    .overrun  (overrun),
    .an       (an),
    .sseg     (sseg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic dt, input logic [15:0] res);
    if (rst) begin
      m_valid   = 1'b0;
      m_value   = 16'h0000;
      m_overrun = 1'b0;
      m_since   = 0;
      m_scan    = 0;
    end else begin
      m_scan  = (m_scan + 1) % 16;
      m_since = m_since + 1;
      if (dt) begin
        if (m_valid && m_since <= HOLD) begin
          m_overrun = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_value = res;
          m_since = 0;
        end
      end
    end
  endtask

  function automatic logic [14:0] model_out();
    int          d;
    logic [15:0] sh;
    logic [3:0]  a;
    logic [7:0]  s;
    logic        rdy, tk;
    d   = m_scan / 4;
    sh  = m_value >> (4 * d);
    a   = ~(4'b0001 << d);
    s   = m_valid ? seg_tab[sh[3:0]] : 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
    if (m_valid && d != 0 && sh == 16'h0000) begin
      a = 4'hF;
      s = 8'hFF;
    end
`endif
    rdy = !(m_valid && m_since < HOLD);
    tk  = m_valid && (m_since == HOLD);
    return {rdy, tk, m_overrun, a, s};
  endfunction

  task automatic step(input logic rst, input logic dt, input logic [15:0] res);
    reset     = rst;
    done_tick = dt;
    result    = res;
    @(posedge clk);
    model_edge(rst, dt, res);
    #1;
    check("model", {17'd0, ready, hold_tick, overrun, an, sseg}, {17'd0, model_out()});
    reset     = 1'b0;
    done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    int n_d0, n_other;
    logic [15:0] r;

    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'hE, 8'hBF};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'hE, 8'hBF};
    vecs[2]  = '{1'b0, 1'b1, 16'h12AF, 1'b0, 1'b0, 1'b0, 4'hE, 8'h8E};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hE, 8'h8E};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hE, 8'h8E};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hD, 8'h88};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hD, 8'h88};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hD, 8'h88};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hD, 8'h88};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'hB, 8'hA4};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'hB, 8'hA4};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'hB, 8'hA4};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'hB, 8'hA4};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h7, 8'hF9};

    // Reset, capture of 12AF, scan through its digits and hold expiry.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].dt, vecs[i].res);
      check($sformatf("vec%0d", i), {17'd0, ready, hold_tick, overrun, an, sseg},
            {17'd0, vecs[i].rdy, vecs[i].tk, vecs[i].ovr, vecs[i].an, vecs[i].sseg});
    end

    // Result arriving while locked is dropped and flagged; a later one in SHOW is taken.
    step(1'b0, 1'b1, 16'h12AF);
    idle(2);
    step(1'b0, 1'b1, 16'h0003);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("still_locked", {31'd0, ready}, 32'd0);
    idle(4);
    step(1'b0, 1'b0, 16'h0000);
    check("expiry", {30'd0, ready, hold_tick}, 32'd3);
    step(1'b0, 1'b1, 16'h0003);
    check("show_capture", {31'd0, ready}, 32'd0);

    // Value 0003 across a full scan: digit 0 shows 3, upper digits zero or blanked.
    n_d0    = 0;
    n_other = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (an == 4'b1110 && sseg == 8'hB0) n_d0++;
`ifdef LEADING_ZERO_BLANK_EN
      if (an == 4'hF && sseg == 8'hFF) n_other++;
`else
      if (an != 4'b1110 && an != 4'hF && sseg == 8'hC0) n_other++;
`endif
    end
    check("digit0_three", n_d0, 32'd4);
    check("upper_digits", n_other, 32'd12);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset in the middle of a hold abandons it.
    step(1'b0, 1'b1, 16'h4321);
    idle(3);
    step(1'b1, 1'b0, 16'h0000);
    check("reset_hold", {20'd0, ready, overrun, hold_tick, an, sseg}, {20'd0, 3'b100, 4'hE, 8'hBF});
    step(1'b0, 1'b0, 16'h0000);
    check("idle_dash", {24'd0, sseg}, 32'h0000_00BF);
    step(1'b0, 1'b1, 16'h5678);
    check("post_reset_capture", {31'd0, ready}, 32'd0);

    // done_tick on the expiry edge is dropped but the hold still ends.
    idle(7);
    step(1'b0, 1'b1, 16'h9999);
    check("expiry_overlap", {29'd0, ready, hold_tick, overrun}, 32'd7);
    idle(16);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = 16'($urandom) >> (4 * $urandom_range(0, 3));
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
